// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: once per video frame, moves the box centre by a bounded
// step derived from the push-buttons (priority) or the accelerometer, then
// clamps it so the square of half-size HALF stays fully on screen.
module box_motion_ctrl #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int HALF        = 25,
    parameter int MAX_SPEED   = 8,
    parameter int DEADZONE    = 16,
    parameter int ACCEL_SHIFT = 5
) (
    input  logic               clk_25mHz,
    input  logic               reset,
    input  logic               screenEnd,
    input  logic               BTNU,
    input  logic               BTNL,
    input  logic               BTNR,
    input  logic               BTND,
    input  logic signed [31:0] accel_x,
    input  logic signed [31:0] accel_y,
    output logic [9:0]         center_x,
    output logic [9:0]         center_y,
    output logic               update_valid,
    output logic [3:0]         hit_edge
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] CLAMP  = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic signed [11:0] SPD   = 12'(MAX_SPEED);
    localparam logic signed [11:0] DZ    = 12'(DEADZONE);
    localparam logic signed [11:0] X_MIN = 12'(HALF);
    localparam logic signed [11:0] X_MAX = 12'(WIDTH - 1 - HALF);
    localparam logic signed [11:0] Y_MIN = 12'(HALF);
    localparam logic signed [11:0] Y_MAX = 12'(HEIGHT - 1 - HALF);
    localparam logic [9:0]         X_RST = 10'(WIDTH / 2);
    localparam logic [9:0]         Y_RST = 10'(HEIGHT / 2);

    // Saturate a 32-bit reading into the signed 12-bit working range.
    function automatic logic signed [11:0] sat12(input logic signed [31:0] a);
        logic signed [11:0] r;
        if (a > 32'sd2047)
            r = 12'sh7FF;
        else if (a < -32'sd2048)
            r = 12'sh800;
        else
            r = a[11:0];
        return r;
    endfunction

    // Accelerometer to step: dead-zone, floor shift, then speed limit.
    function automatic logic signed [11:0] accel_step(input logic signed [31:0] a);
        logic signed [11:0] s;
        logic signed [11:0] q;
        logic signed [11:0] r;
        s = sat12(a);
        q = s >>> ACCEL_SHIFT;
        if (s > -DZ && s < DZ)
            r = '0;
        else if (q > SPD)
            r = SPD;
        else if (q < -SPD)
            r = -SPD;
        else
            r = q;
        return r;
    endfunction

    // Per-axis step: a single held button wins, opposing buttons cancel,
    // otherwise the accelerometer decides.
    function automatic logic signed [11:0] axis_step(input logic neg_btn,
                                                     input logic pos_btn,
                                                     input logic signed [31:0] a);
        logic signed [11:0] r;
        if (pos_btn && !neg_btn)
            r = SPD;
        else if (neg_btn && !pos_btn)
            r = -SPD;
        else if (neg_btn && pos_btn)
            r = '0;
        else
            r = accel_step(a);
        return r;
    endfunction

    logic [1:0]         state;
    logic [3:0]         btn_meta;     // {U, D, L, R}
    logic [3:0]         btn_sync;     // {U, D, L, R}
    logic               se_prev;
    logic               frame_evt;
    logic signed [11:0] next_x_p0;
    logic signed [11:0] next_y_p0;
    logic signed [11:0] clamp_x_p1;
    logic signed [11:0] clamp_y_p1;
    logic               lo_x_p1;
    logic               hi_x_p1;
    logic               lo_y_p1;
    logic               hi_y_p1;

    assign frame_evt = screenEnd & ~se_prev;

    // Control path: FSM, button synchronisers, frame edge detector and the
    // output registers. Outputs load on the edge into COMMIT so the new
    // centre and update_valid are both present for the whole COMMIT cycle.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            btn_meta     <= '0;
            btn_sync     <= '0;
            se_prev      <= 1'b0;
            center_x     <= X_RST;
            center_y     <= Y_RST;
            update_valid <= 1'b0;
            hit_edge     <= '0;
        end else begin
            btn_meta     <= {BTNU, BTND, BTNL, BTNR};
            btn_sync     <= btn_meta;
            se_prev      <= screenEnd;
            update_valid <= 1'b0;
            case (state)
                IDLE:   if (frame_evt) state <= CALC;
                CALC:   state <= CLAMP;
                CLAMP: begin
                    state        <= COMMIT;
                    center_x     <= clamp_x_p1[9:0];
                    center_y     <= clamp_y_p1[9:0];
                    hit_edge     <= {lo_y_p1, hi_y_p1, lo_x_p1, hi_x_p1};
                    update_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CALC stage: accel is sampled here and the unclamped next centre formed.
    always_ff @(posedge clk_25mHz) begin
        if (state == CALC) begin
            next_x_p0 <= $signed({2'b00, center_x}) + axis_step(btn_sync[1], btn_sync[0], accel_x);
            next_y_p0 <= $signed({2'b00, center_y}) + axis_step(btn_sync[3], btn_sync[2], accel_y);
        end
    end

    // CLAMP stage: bound each axis to the on-screen range and flag the edge hit.
    always_comb begin
        lo_x_p1    = next_x_p0 < X_MIN;
        hi_x_p1    = next_x_p0 > X_MAX;
        lo_y_p1    = next_y_p0 < Y_MIN;
        hi_y_p1    = next_y_p0 > Y_MAX;
        clamp_x_p1 = next_x_p0;
        clamp_y_p1 = next_y_p0;
        if (lo_x_p1)
            clamp_x_p1 = X_MIN;
        else if (hi_x_p1)
            clamp_x_p1 = X_MAX;
        if (lo_y_p1)
            clamp_y_p1 = Y_MIN;
        else if (hi_y_p1)
            clamp_y_p1 = Y_MAX;
    end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Testbench for box_motion_ctrl: directed scenarios with literal expectations
// plus randomized stimulus, all checked each cycle against a frame-level model.
module tb_box_motion_ctrl;

    localparam int WIDTH = 640, HEIGHT = 480, HALF = 25;
    localparam int MAX_SPEED = 8, DEADZONE = 16, ACCEL_SHIFT = 5;

    logic               clk_25mHz = 1'b0;
    logic               reset = 1'b1;
    logic               screenEnd = 1'b0;
    logic               BTNU = 1'b0, BTNL = 1'b0, BTNR = 1'b0, BTND = 1'b0;
    logic signed [31:0] accel_x = '0, accel_y = '0;
    logic [9:0]         center_x, center_y;
    logic               update_valid;
    logic [3:0]         hit_edge;

    int checks = 0;
    int errors = 0;

    box_motion_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .HALF(HALF),
        .MAX_SPEED(MAX_SPEED), .DEADZONE(DEADZONE), .ACCEL_SHIFT(ACCEL_SHIFT)
    ) dut (
        .clk_25mHz(clk_25mHz), .reset(reset), .screenEnd(screenEnd),
        .BTNU(BTNU), .BTNL(BTNL), .BTNR(BTNR), .BTND(BTND),
        .accel_x(accel_x), .accel_y(accel_y),
        .center_x(center_x), .center_y(center_y),
        .update_valid(update_valid), .hit_edge(hit_edge)
    );

    always #20 clk_25mHz = ~clk_25mHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Step for one axis from the behavioural rules, using plain integer math.
    function automatic int model_step(bit neg, bit pos, longint a);
        longint s;
        int q;
        if (pos && !neg) return MAX_SPEED;
        if (neg && !pos) return -MAX_SPEED;
        if (neg && pos) return 0;
        s = (a > 2047) ? 2047 : ((a < -2048) ? -2048 : a);
        if (s > -DEADZONE && s < DEADZONE) return 0;
        if (s >= 0) q = int'(s / (1 << ACCEL_SHIFT));
        else        q = -int'((-s + (1 << ACCEL_SHIFT) - 1) / (1 << ACCEL_SHIFT));
        if (q > MAX_SPEED) q = MAX_SPEED;
        if (q < -MAX_SPEED) q = -MAX_SPEED;
        return q;
    endfunction

    // Reference model state
    int       cyc = 0, calc_cyc = -1, commit_cyc = -1, free_cyc = 0;
    int       exp_x = WIDTH / 2, exp_y = HEIGHT / 2, pend_x = 0, pend_y = 0;
    logic [3:0] exp_hit = '0, pend_hit = '0;
    bit       exp_uv = 1'b0, prev_se = 1'b0;
    logic [3:0] h0 = '0, h1 = '0, h2 = '0;   // raw {U,D,L,R}: this, 1 and 2 cycles ago

    // Model advance and compare, once per cycle on the falling edge.
    always @(negedge clk_25mHz) begin
        int sx, sy, nx, ny;
        cyc++;
        if (!reset) begin
            exp_x = WIDTH / 2; exp_y = HEIGHT / 2; exp_hit = '0; exp_uv = 1'b0;
            calc_cyc = -1; commit_cyc = -1; free_cyc = 0; prev_se = 1'b0;
            h0 = '0; h1 = '0; h2 = '0;
        end else begin
            h2 = h1; h1 = h0; h0 = {BTNU, BTND, BTNL, BTNR};
            exp_uv = (cyc == commit_cyc);
            if (exp_uv) begin
                exp_x = pend_x; exp_y = pend_y; exp_hit = pend_hit;
            end
        end
        chk("update_valid", 32'(update_valid), 32'(exp_uv));
        chk("center_x", 32'(center_x), 32'(exp_x));
        chk("center_y", 32'(center_y), 32'(exp_y));
        chk("hit_edge", 32'(hit_edge), 32'(exp_hit));
        if (reset) begin
            if (cyc == calc_cyc) begin
                sx = model_step(h2[1], h2[0], longint'(accel_x));
                sy = model_step(h2[3], h2[2], longint'(accel_y));
                nx = exp_x + sx; ny = exp_y + sy;
                pend_hit = '0;
                if (ny < HALF)              begin ny = HALF;              pend_hit[3] = 1'b1; end
                if (ny > HEIGHT - 1 - HALF) begin ny = HEIGHT - 1 - HALF; pend_hit[2] = 1'b1; end
                if (nx < HALF)              begin nx = HALF;              pend_hit[1] = 1'b1; end
                if (nx > WIDTH - 1 - HALF)  begin nx = WIDTH - 1 - HALF;  pend_hit[0] = 1'b1; end
                pend_x = nx; pend_y = ny;
                commit_cyc = cyc + 2;
            end
            if (screenEnd && !prev_se && cyc >= free_cyc) begin
                calc_cyc = cyc + 1;
                free_cyc = cyc + 4;
            end
            prev_se = screenEnd;
        end
    end

    task automatic set_in(input bit u, input bit d, input bit l, input bit r,
                          input logic signed [31:0] ax, input logic signed [31:0] ay);
        @(posedge clk_25mHz); #1;
        BTNU = u; BTND = d; BTNL = l; BTNR = r; accel_x = ax; accel_y = ay;
    endtask

    // One frame event, then a bounded wait for the update pulse.
    task automatic do_frame();
        bit got;
        repeat (3) @(posedge clk_25mHz);
        #1 screenEnd = 1'b1;
        @(posedge clk_25mHz); #1 screenEnd = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk_25mHz);
            if (update_valid === 1'b1) got = 1'b1;
        end
        chk("frame_update_seen", 32'(got), 32'd1);
    endtask

    function automatic logic signed [31:0] rand_accel();
        case ($urandom_range(0, 4))
            0: return 32'(int'($urandom_range(0, 40)) - 20);
            1: return 32'(int'($urandom_range(0, 800)) - 400);
            2: return $urandom;
            3: return 32'h7FFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        int cnt;
        logic [7:0] pat;
        #5 reset = 1'b0;
        repeat (2) @(posedge clk_25mHz);
        @(negedge clk_25mHz);
        chk("rst_center_x", 32'(center_x), 32'd320);
        chk("rst_center_y", 32'(center_y), 32'd240);
        chk("rst_update_valid", 32'(update_valid), 32'd0);
        chk("rst_hit_edge", 32'(hit_edge), 32'd0);
        @(posedge clk_25mHz); #1 reset = 1'b1;

        do_frame();
        chk("idle_frame_x", 32'(center_x), 32'd320);
        chk("idle_frame_y", 32'(center_y), 32'd240);

        set_in(0, 0, 0, 1, 0, 0);
        do_frame(); chk("btnr_1", 32'(center_x), 32'd328);
        do_frame(); chk("btnr_2", 32'(center_x), 32'd336);
        do_frame(); chk("btnr_3", 32'(center_x), 32'd344);
        chk("btnr_y", 32'(center_y), 32'd240);
        chk("btnr_hit", 32'(hit_edge), 32'd0);

        set_in(0, 0, 0, 0, 32'sd10, 0);   do_frame(); chk("accel_10", 32'(center_x), 32'd344);
        set_in(0, 0, 0, 0, 32'sd160, 0);  do_frame(); chk("accel_160", 32'(center_x), 32'd349);
        set_in(0, 0, 0, 0, -32'sd170, 0); do_frame(); chk("accel_m170", 32'(center_x), 32'd343);
        set_in(0, 0, 0, 0, 32'h7FFF_FFFF, 0); do_frame(); chk("accel_max", 32'(center_x), 32'd351);
        set_in(0, 0, 0, 0, 32'h8000_0000, 0); do_frame(); chk("accel_min", 32'(center_x), 32'd343);
        set_in(0, 0, 0, 0, 0, 32'sd96);   do_frame(); chk("accel_y96", 32'(center_y), 32'd243);

        set_in(0, 0, 1, 1, 32'sd2000, 0); do_frame(); chk("btn_lr_cancel", 32'(center_x), 32'd343);
        set_in(1, 0, 0, 0, 0, 32'sd2000); do_frame(); chk("btnu_override", 32'(center_y), 32'd235);

        set_in(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 33; i++) do_frame();
        chk("walk_right", 32'(center_x), 32'd607);
        set_in(0, 0, 0, 0, 32'sd96, 0); do_frame(); chk("reach_610", 32'(center_x), 32'd610);
        set_in(0, 0, 0, 1, 0, 0);
        do_frame(); chk("right_clamp_x", 32'(center_x), 32'd614);
        chk("right_clamp_hit", 32'(hit_edge), 32'b0001);
        do_frame(); chk("right_again_x", 32'(center_x), 32'd614);
        chk("right_again_hit", 32'(hit_edge), 32'b0001);
        set_in(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 73; i++) do_frame();
        chk("walk_left", 32'(center_x), 32'd30);
        do_frame(); chk("left_clamp_x", 32'(center_x), 32'd25);
        chk("left_clamp_hit", 32'(hit_edge), 32'b0010);
        set_in(0, 0, 0, 0, 0, 0);

        // Extra rising edges while busy must be dropped.
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 8'b0000_0101 : 8'b0000_1001;
            cnt = 0;
            repeat (3) @(posedge clk_25mHz);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk_25mHz); #1 screenEnd = (i < 8) ? pat[i] : 1'b0;
                @(negedge clk_25mHz);
                if (update_valid === 1'b1) cnt++;
            end
            chk("busy_drop_pulses", 32'(cnt), 32'd1);
        end

        // Reset during CLAMP discards the update.
        repeat (3) @(posedge clk_25mHz);
        #1 screenEnd = 1'b1;
        @(posedge clk_25mHz); #1 screenEnd = 1'b0;
        @(posedge clk_25mHz); #2 reset = 1'b0;
        @(negedge clk_25mHz);
        chk("midrst_x", 32'(center_x), 32'd320);
        chk("midrst_y", 32'(center_y), 32'd240);
        @(posedge clk_25mHz); #1 reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_25mHz);
            if (update_valid === 1'b1) cnt++;
        end
        chk("midrst_no_pulse", 32'(cnt), 32'd0);

        // Randomized stimulus; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_25mHz); #1;
            if ($urandom_range(0, 7) == 0)
                {BTNU, BTND, BTNL, BTNR} = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 5) == 0) accel_x = rand_accel();
            if ($urandom_range(0, 5) == 0) accel_y = rand_accel();
            screenEnd = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk_25mHz); #1 screenEnd = 1'b0;
        repeat (8) @(posedge clk_25mHz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/box_motion_ctrl.md
Name: box_motion_ctrl

Overview:
- Computes the on-screen box centre once per video frame from the push-buttons and the signed accelerometer readings.
- Sits directly upstream of the VGA controller, which draws a square of half-size HALF around the centre it receives.
- Replaces the raw accel-to-pixel mapping with velocity-style movement: dead-zone, speed limit and clamping to the screen edges.

Parameters:
WIDTH, 640, visible screen width in pixels
HEIGHT, 480, visible screen height in pixels
HALF, 25, box half-size; the centre is clamped to [HALF, WIDTH-1-HALF] and [HALF, HEIGHT-1-HALF]
MAX_SPEED, 8, maximum step magnitude in pixels per frame, per axis
DEADZONE, 16, accel readings with magnitude below this give a step of 0
ACCEL_SHIFT, 5, arithmetic right-shift applied to the saturated accel value

Ports:
clk_25mHz  in  1  pixel clock; sole clock of the block
reset  in  1  asynchronous reset, active-low
screenEnd  in  1  frame-boundary strobe from the timing generator
BTNU  in  1  move up, asynchronous
BTNL  in  1  move left, asynchronous
BTNR  in  1  move right, asynchronous
BTND  in  1  move down, asynchronous
accel_x  in  32  signed two's complement; positive moves right
accel_y  in  32  signed two's complement; positive moves down
center_x  out  10  box centre X
center_y  out  10  box centre Y
update_valid  out  1  one-cycle pulse when the centre registers change
hit_edge  out  4  {top, bottom, left, right}; clamp occurred on the last update

Behaviour:
- Reset (reset=0, asynchronous):
  - center_x=WIDTH/2 (320), center_y=HEIGHT/2 (240).
  - update_valid=0, hit_edge=0.
  - FSM to IDLE; synchronisers and edge detector cleared.
- Input conditioning:
  - Buttons pass through 2-flop synchronisers.
  - screenEnd is rising-edge detected (registered copy); a frame event is screenEnd=1 and prev=0.
  - accel inputs are sampled only in CALC.
- FSM states: IDLE, CALC, CLAMP, COMMIT.
  - IDLE -> CALC on a frame event.
  - CALC -> CLAMP -> COMMIT -> IDLE unconditionally, one cycle each.
  - Frame events arriving outside IDLE are dropped, not queued.
- CALC, per axis (X uses L/R and accel_x; Y uses U/D and accel_y):
  - Exactly one direction button held: step = ±MAX_SPEED; buttons override accel.
  - Both opposing buttons held: step = 0; accel ignored.
  - No button held:
    - Saturate accel to signed 12-bit [-2048, 2047].
    - If |a| < DEADZONE: step = 0.
    - Else step = a >>> ACCEL_SHIFT (floor), then limited to [-MAX_SPEED, MAX_SPEED].
  - Sum: next = center + step, computed in signed 12 bits with no wrap.
- CLAMP, per axis:
  - If next < HALF: next = HALF.
  - If next > LIMIT-1-HALF: next = LIMIT-1-HALF.
  - Set the matching hit_edge bit for each bound applied; clear the others.
- COMMIT:
  - center_x, center_y and hit_edge register.
  - update_valid=1 for exactly this cycle.
- Timing:
  - Latency: frame-event cycle N -> new centre and update_valid visible at cycle N+3.
  - Outputs are stable from COMMIT until the next COMMIT.
  - update_valid pulses even when the step is 0.
- Reset mid-operation: reset asserted in any state restores reset values immediately; the partial update is discarded.
- Throughput: at most one update per frame; 3 busy cycles per 420,000-cycle frame.

Test Plan:
- Reset, release, no stimulus -> center=(320,240), update_valid=0, hit_edge=0; after 1 frame event -> update_valid pulses at N+3, center unchanged.
- BTNR held, 3 frame events -> center_x 328, 336, 344; center_y stays 240; hit_edge=0.
- Right-edge clamp:
  - BTNR held from center_x=610 -> 614, hit_edge=4'b0001.
  - Next frame -> 614 again, hit_edge still set.
  - BTNL from 30 -> 25, hit_edge=4'b0010.
- accel_x sweep, no buttons:
  - 10 -> step 0.
  - 160 -> +5.
  - -170 -> -6.
  - 0x7FFFFFFF -> saturates, +8.
  - 0x80000000 -> -8.
  - accel_y=96 -> center_y +3.
- Precedence: BTNL+BTNR held with accel_x=2000 -> center_x unchanged; BTNU alone with accel_y=2000 -> center_y -8.
- Corner cases:
  - Second screenEnd pulse during CALC -> ignored, exactly one update.
  - reset pulsed low during CLAMP -> center=(320,240), no update_valid pulse.
